display_timing: RTL and testbench

//  - Raster timing generator; drives the pixel-side pattern/display blocks.
//  - Produces signed pixel coordinates (o_x, o_y), a frame-start pulse (o_frame),
//    a line-start pulse (o_line), sync (o_hsync, o_vsync) and data enable (o_de).
//  - Coordinates are negative during blanking and 0..RES-1 in the active area.
//  - Sits between the pixel clock domain and the VGA DAC pins. Pattern blocks

---
 rtl/display_timing_if.sv | 13 +
 rtl/display_timing.sv | 108 ++++++++++
 tb/tb_display_timing.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/display_timing_if.sv
// Raster timing bundle from the generator to pixel-side pattern/display blocks.
interface display_timing_if;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               frame;
  logic               line;

  modport master (output x, y, hsync, vsync, de, frame, line);
  modport slave  (input  x, y, hsync, vsync, de, frame, line);
endinterface

// File: rtl/display_timing.sv
// Free-running raster timing generator with signed coordinates (negative in blanking).
// Optional macro DISPLAY_TIMING_PIPE_EN adds one register stage on hsync/vsync/de.
module display_timing #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  display_timing_if.master   bus
);

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);
  localparam int H_TOTAL = H_RES - H_STA_I;
  localparam int V_TOTAL = V_RES - V_STA_I;

  localparam logic signed [15:0] H_STA  = 16'(H_STA_I);
  localparam logic signed [15:0] V_STA  = 16'(V_STA_I);
  localparam logic signed [15:0] H_END  = 16'(H_RES - 1);
  localparam logic signed [15:0] V_END  = 16'(V_RES - 1);
  localparam logic signed [15:0] HS_BEG = 16'(H_STA_I + H_FP);
  localparam logic signed [15:0] HS_END = 16'(H_STA_I + H_FP + H_SYNC - 1);
  localparam logic signed [15:0] VS_BEG = 16'(V_STA_I + V_FP);
  localparam logic signed [15:0] VS_END = 16'(V_STA_I + V_FP + V_SYNC - 1);

  // Totals must fit the signed 16-bit counters.
  if (H_TOTAL > 32767 || V_TOTAL > 32767) begin : g_bad_totals
    $error("display_timing: H/V totals must not exceed 32767");
  end

  logic signed [15:0] x, y, x_nxt, y_nxt;
  logic hs_nxt, vs_nxt, de_nxt, frame_nxt, line_nxt;
  logic hs_r, vs_r, de_r, frame_r, line_r;

  // Decodes look at the next counter values so registered outputs stay aligned with x/y.
  always_comb begin
    x_nxt = x + 16'sd1;
    y_nxt = y;
    if (x == H_END) begin
      x_nxt = H_STA;
      y_nxt = (y == V_END) ? V_STA : y + 16'sd1;
    end
    hs_nxt    = (x_nxt >= HS_BEG && x_nxt <= HS_END) ? H_POL : ~H_POL;
    vs_nxt    = (y_nxt >= VS_BEG && y_nxt <= VS_END) ? V_POL : ~V_POL;
    de_nxt    = !x_nxt[15] && !y_nxt[15];
    frame_nxt = (x_nxt == H_STA) && (y_nxt == V_STA);
    line_nxt  = (x_nxt == H_STA);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x       <= H_STA;
      y       <= V_STA;
      hs_r    <= ~H_POL;
      vs_r    <= ~V_POL;
      de_r    <= 1'b0;
      frame_r <= 1'b0;
      line_r  <= 1'b0;
    end else begin
      x       <= x_nxt;
      y       <= y_nxt;
      hs_r    <= hs_nxt;
      vs_r    <= vs_nxt;
      de_r    <= de_nxt;
      frame_r <= frame_nxt;
      line_r  <= line_nxt;
    end
  end

  assign bus.x     = x;
  assign bus.y     = y;
  assign bus.frame = frame_r;
  assign bus.line  = line_r;

`ifdef DISPLAY_TIMING_PIPE_EN
  logic hs_q, vs_q, de_q;

  // Extra stage lines sync/de up with one registered colour stage downstream.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b0;
    end else begin
      hs_q <= hs_r;
      vs_q <= vs_r;
      de_q <= de_r;
    end
  end

  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
  assign bus.de    = de_q;
`else
  assign bus.hsync = hs_r;
  assign bus.vsync = vs_r;
  assign bus.de    = de_r;
`endif

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: small-geometry instance checked every cycle against an
// arithmetic raster model, plus a default-geometry instance checked after reset.
module tb_display_timing;

  localparam int HR = 16, HF = 2, HS = 3, HB = 4;
  localparam int VR = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HR + HF + HS + HB;
  localparam int VT = VR + VF + VS + VB;
  localparam int HSTA = -(HF + HS + HB);
  localparam int VSTA = -(VF + VS + VB);
  localparam int FRAME_LEN = HT * VT;
  localparam int WIN_LO = 50;
`ifdef DISPLAY_TIMING_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_timing_if bus();
  display_timing_if bus0();

  display_timing #(
    .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  display_timing dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Position in the raster is just the cycle count since the reset state, modulo a frame.
  function automatic void modelAt(input int k, output int mx, output int my,
                                  output bit mh, output bit mv, output bit mde,
                                  output bit mfr, output bit mln);
    int p;
    p   = k % FRAME_LEN;
    mx  = HSTA + p % HT;
    my  = VSTA + p / HT;
    mh  = (mx >= HSTA + HF && mx < HSTA + HF + HS) ? 1'b0 : 1'b1;
    mv  = (my >= VSTA + VF && my < VSTA + VF + VS) ? 1'b0 : 1'b1;
    mde = (mx >= 0) && (my >= 0);
    mfr = (p == 0) && (k != 0);
    mln = (p % HT == 0) && (k != 0);
  endfunction

  int n = 0;
  bit valid = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      n     <= 0;
      valid <= 1'b1;
    end else if (valid) begin
      n <= n + 1;
    end
  end

  int frame_at[$];
  int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, ln_cnt = 0, fr_cnt = 0;
  int hs_run = 0, hs_max = 0;

  // Per-cycle compare against the model, plus window statistics for the literal checks.
  always @(negedge clk) begin
    int mx, my, px, py;
    bit mh, mv, mde, mfr, mln, ph, pv, pde, pfr, pln;
    if (valid) begin
      modelAt(n, mx, my, mh, mv, mde, mfr, mln);
      if (PIPE) begin
        if (n == 0) begin
          mh = 1'b1; mv = 1'b1; mde = 1'b0;
        end else begin
          modelAt(n - 1, px, py, ph, pv, pde, pfr, pln);
          mh = ph; mv = pv; mde = pde;
        end
      end
      checkOutput("x",     longint'($signed(bus.x)), longint'(mx));
      checkOutput("y",     longint'($signed(bus.y)), longint'(my));
      checkOutput("hsync", longint'(bus.hsync), longint'(mh));
      checkOutput("vsync", longint'(bus.vsync), longint'(mv));
      checkOutput("de",    longint'(bus.de),    longint'(mde));
      checkOutput("frame", longint'(bus.frame), longint'(mfr));
      checkOutput("line",  longint'(bus.line),  longint'(mln));
      if (bus.frame) frame_at.push_back(n);
      if (n >= WIN_LO && n < WIN_LO + FRAME_LEN) begin
        hs_cnt += (bus.hsync == 1'b0) ? 1 : 0;
        vs_cnt += (bus.vsync == 1'b0) ? 1 : 0;
        de_cnt += bus.de ? 1 : 0;
        ln_cnt += bus.line ? 1 : 0;
        fr_cnt += bus.frame ? 1 : 0;
      end
      hs_run = (bus.hsync == 1'b0) ? hs_run + 1 : 0;
      if (hs_run > hs_max) hs_max = hs_run;
    end
  end

  task automatic applyStimulus(input bit rst, input int cycles);
    @(negedge clk);
    rst_n = rst;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int mx, my;
    bit mh, mv, mde, mfr, mln;

    applyStimulus(1'b0, 2);
    checkOutput("rst_x",     longint'($signed(bus.x)), -9);
    checkOutput("rst_y",     longint'($signed(bus.y)), -5);
    checkOutput("rst_hsync", longint'(bus.hsync), 1);
    checkOutput("rst_vsync", longint'(bus.vsync), 1);
    checkOutput("rst_de",    longint'(bus.de), 0);
    checkOutput("rst_frame", longint'(bus.frame), 0);
    checkOutput("rst_line",  longint'(bus.line), 0);
    checkOutput("dflt_rst_x", longint'($signed(bus0.x)), -160);
    checkOutput("dflt_rst_y", longint'($signed(bus0.y)), -45);

    applyStimulus(1'b1, 1);
    checkOutput("first_x",     longint'($signed(bus.x)), -8);
    checkOutput("first_y",     longint'($signed(bus.y)), -5);
    checkOutput("first_frame", longint'(bus.frame), 0);
    checkOutput("dflt_first_x",     longint'($signed(bus0.x)), -159);
    checkOutput("dflt_first_y",     longint'($signed(bus0.y)), -45);
    checkOutput("dflt_first_de",    longint'(bus0.de), 0);
    checkOutput("dflt_first_hsync", longint'(bus0.hsync), 1);
    checkOutput("dflt_first_vsync", longint'(bus0.vsync), 1);
    checkOutput("dflt_first_frame", longint'(bus0.frame), 0);

    @(negedge clk);
    checkOutput("hs_edge_x", longint'($signed(bus.x)), -7);
    checkOutput("hs_edge_lead", longint'(bus.hsync), PIPE ? 1 : 0);
    @(negedge clk);
    checkOutput("hs_edge_next", longint'(bus.hsync), 0);

    while (n < 600) @(negedge clk);
    checkOutput("frame_pulses", frame_at.size(), 2);
    checkOutput("frame0_cycle", (frame_at.size() > 0) ? frame_at[0] : -1, FRAME_LEN);
    checkOutput("frame1_cycle", (frame_at.size() > 1) ? frame_at[1] : -1, 2 * FRAME_LEN);
    checkOutput("hsync_per_frame", hs_cnt, HS * VT);
    checkOutput("vsync_per_frame", vs_cnt, VS * HT);
    checkOutput("de_per_frame",    de_cnt, HR * VR);
    checkOutput("line_per_frame",  ln_cnt, VT);
    checkOutput("frame_per_frame", fr_cnt, 1);
    checkOutput("hsync_run",       hs_max, HS);

    modelAt(189, mx, my, mh, mv, mde, mfr, mln);
    checkOutput("model_x_189", mx, 5);
    checkOutput("model_y_189", my, 2);

    while (n < 600 + 189 - 600 % FRAME_LEN + FRAME_LEN - FRAME_LEN) @(negedge clk);
    while (n % FRAME_LEN != 189) @(negedge clk);
    checkOutput("mid_x", longint'($signed(bus.x)), 5);
    checkOutput("mid_y", longint'($signed(bus.y)), 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_x",     longint'($signed(bus.x)), -9);
    checkOutput("midrst_y",     longint'($signed(bus.y)), -5);
    checkOutput("midrst_de",    longint'(bus.de), 0);
    checkOutput("midrst_hsync", longint'(bus.hsync), 1);
    checkOutput("midrst_frame", longint'(bus.frame), 0);
    frame_at.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart_x", longint'($signed(bus.x)), -8);
    while (n < 300) @(negedge clk);
    checkOutput("restart_pulses", frame_at.size(), 1);
    checkOutput("restart_frame_cycle", (frame_at.size() > 0) ? frame_at[0] : -1, FRAME_LEN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
